// File: rtl/gpr_wb_arbiter_if.sv
// Result-producer / GPR write-port bundle for gpr_wb_arbiter.
// The fwd_* lookup signals exist only when GPR_WB_FWD_EN is defined.
interface gpr_wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [SRC_W-1:0]          wr_src;
  logic                      busy;
`ifdef GPR_WB_FWD_EN
  logic [ADDR_W-1:0]         fwd_addr;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;

  modport slave (
    input  src_valid, src_addr, src_data, fwd_addr,
    output src_ready, wr_en, wr_addr, wr_data, wr_src, busy, fwd_hit, fwd_data
  );
  modport master (
    output src_valid, src_addr, src_data, fwd_addr,
    input  src_ready, wr_en, wr_addr, wr_data, wr_src, busy, fwd_hit, fwd_data
  );
`else
  modport slave (
    input  src_valid, src_addr, src_data,
    output src_ready, wr_en, wr_addr, wr_data, wr_src, busy
  );
  modport master (
    output src_valid, src_addr, src_data,
    input  src_ready, wr_en, wr_addr, wr_data, wr_src, busy
  );
`endif
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: per-source one-entry skid buffers, aged priority grant, registered write port.
// Optional GPR_WB_FWD_EN adds a combinational forwarding lookup over buffers and the write port.

// One holding buffer plus its starvation age counter.
module gpr_wb_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              gnt,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              full,
  output logic [3:0]        age,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  logic              full_q, full_d;
  logic [3:0]        age_q, age_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load wins over a same-cycle grant: that is the skid reload.
  always_comb begin
    full_d = full_q;
    age_d  = age_q;
    addr_d = addr_q;
    data_d = data_q;
    if (ld) begin
      full_d = 1'b1;
      age_d  = '0;
      addr_d = ld_addr;
      data_d = ld_data;
    end else if (gnt || !full_q) begin
      full_d = 1'b0;
      age_d  = '0;
    end else if (age_q != 4'hF) begin
      age_d = age_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      age_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      age_q  <= age_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign age  = age_q;
  assign addr = addr_q;
  assign data = data_q;
endmodule

module gpr_wb_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  gpr_wb_arbiter_if.slave  bus
);
  localparam int         SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NUM_SRC-1:0]             full, gnt, rdy, acc;
  logic [NUM_SRC-1:0][3:0]        age;
  logic [NUM_SRC-1:0][ADDR_W-1:0] buf_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] buf_data;

  assign rdy = ~full | gnt;
  assign acc = bus.src_valid & rdy;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    gpr_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .ld      (acc[i]),
      .gnt     (gnt[i]),
      .ld_addr (bus.src_addr[i*ADDR_W +: ADDR_W]),
      .ld_data (bus.src_data[i*DATA_W +: DATA_W]),
      .full    (full[i]),
      .age     (age[i]),
      .addr    (buf_addr[i]),
      .data    (buf_data[i])
    );
  end

  // Starved entries form an upper priority tier; fixed index order within each tier.
  always_comb begin
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && full[i] && age[i] >= LIMIT) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && full[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [SRC_W-1:0]  wr_src_q, wr_src_d;

  always_comb begin
    wr_en_d   = |gnt;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        wr_addr_d = buf_addr[i];
        wr_data_d = buf_data[i];
        wr_src_d  = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign bus.src_ready = rdy;
  assign bus.busy      = |full;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;

`ifdef GPR_WB_FWD_EN
  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;

  // Buffers are scanned last so they override a write-port match.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    if (wr_en_q && wr_addr_q == bus.fwd_addr) begin
      fwd_hit_c  = 1'b1;
      fwd_data_c = wr_data_q;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (full[i] && buf_addr[i] == bus.fwd_addr) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = buf_data[i];
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_data_c;
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: per-cycle vector table plus starvation and mid-op reset sequences.
module tb_gpr_wb_arbiter;
  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NROWS   = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  gpr_wb_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]  vld;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ws;
    logic        busy;
  } vec_t;

  vec_t vt [NROWS];

  task automatic setrow(input int i, input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input logic [2:0] r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [1:0] ws, input logic b);
    vt[i].vld = v;  vt[i].addr = a; vt[i].data = d; vt[i].rdy = r;
    vt[i].we  = we; vt[i].wa = wa;  vt[i].wd = wd;  vt[i].ws = ws; vt[i].busy = b;
  endtask

  // Independent occupancy model: a grant is observed one edge later as wr_en/wr_src.
  logic [2:0]      acc_q  = '0;
  logic [14:0]     addr_q = '0;
  logic            rst_q  = 1'b1;
  logic [2:0]      occ    = '0;
  logic [2:0][4:0] occ_addr = '0;
  logic            mon_en = 1'b0;

  always @(posedge clk) begin
    acc_q  <= bus.src_valid & bus.src_ready;
    addr_q <= bus.src_addr;
    rst_q  <= reset;
  end

  always @(negedge clk) begin : mon
    logic [2:0]      g, nocc;
    logic [2:0][4:0] naddr;
    g = '0;
    if (bus.wr_en && bus.wr_src < 2'd3) g[bus.wr_src] = 1'b1;
    nocc  = rst_q ? 3'b000 : ((occ & ~g) | acc_q);
    naddr = occ_addr;
    for (int i = 0; i < 3; i++) if (acc_q[i]) naddr[i] = addr_q[i*5 +: 5];
    occ      <= nocc;
    occ_addr <= naddr;
    if (mon_en) begin
      chk("busy_model", {31'b0, bus.busy}, {31'b0, |nocc});
      for (int i = 0; i < 3; i++)
        for (int j = i + 1; j < 3; j++)
          if (nocc[i] && nocc[j]) begin
            checks++;
            if (naddr[i] == naddr[j]) begin
              failures++;
              $display("FAIL addr_unique src%0d src%0d both hold addr %0d", i, j, naddr[i]);
            end
          end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [4:0] s0_addr(input int k);
    return (k == 4) ? 5'd12 : 5'(20 + k);
  endfunction
  function automatic logic [31:0] s0_data(input int k);
    return (k == 4) ? 32'hABCD : 32'h200 + 32'(k);
  endfunction

  initial begin
    int k0;
    bus.src_valid = '0;
    bus.src_addr  = '0;
    bus.src_data  = '0;
`ifdef GPR_WB_FWD_EN
    bus.fwd_addr  = '0;
`endif

    // Single source, collision, then an 8-deep stream from src 1.
    setrow(0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b111, 0, 5'd0, 32'h0, 2'd0, 0);
    setrow(1, 3'b000, 15'd0, 96'd0, 3'b111, 0, 5'd0, 32'h0, 2'd0, 1);
    setrow(2, 3'b000, 15'd0, 96'd0, 3'b111, 1, 5'd7, 32'hDEADBEEF, 2'd1, 0);
    setrow(3, 3'b101, {5'd9, 5'd0, 5'd3}, {32'h22, 32'h0, 32'h11}, 3'b111, 0, 5'd7, 32'hDEADBEEF, 2'd1, 0);
    setrow(4, 3'b000, 15'd0, 96'd0, 3'b011, 0, 5'd7, 32'hDEADBEEF, 2'd1, 1);
    setrow(5, 3'b000, 15'd0, 96'd0, 3'b111, 1, 5'd3, 32'h11, 2'd0, 1);
    setrow(6, 3'b000, 15'd0, 96'd0, 3'b111, 1, 5'd9, 32'h22, 2'd2, 0);
    setrow(7, 3'b000, 15'd0, 96'd0, 3'b111, 0, 5'd9, 32'h22, 2'd2, 0);
    for (int k = 0; k < 8; k++)
      setrow(8 + k, 3'b010, {5'd0, 5'(10 + k), 5'd0}, {32'h0, 32'h100 + 32'(k), 32'h0}, 3'b111,
             k >= 2, (k >= 2) ? 5'(8 + k) : 5'd9, (k >= 2) ? 32'h100 + 32'(k - 2) : 32'h22,
             (k >= 2) ? 2'd1 : 2'd2, k >= 1);
    setrow(16, 3'b000, 15'd0, 96'd0, 3'b111, 1, 5'd16, 32'h106, 2'd1, 1);
    setrow(17, 3'b000, 15'd0, 96'd0, 3'b111, 1, 5'd17, 32'h107, 2'd1, 0);
    setrow(18, 3'b000, 15'd0, 96'd0, 3'b111, 0, 5'd17, 32'h107, 2'd1, 0);

    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
`ifdef GPR_WB_FWD_EN
    #1;
    chk("reset_fwd_hit", {31'b0, bus.fwd_hit}, 32'd0);
    chk("reset_fwd_data", bus.fwd_data, 32'd0);
`endif

    for (int i = 0; i < NROWS; i++) begin
      if (i > 0) @(negedge clk);
      bus.src_valid = vt[i].vld;
      bus.src_addr  = vt[i].addr;
      bus.src_data  = vt[i].data;
      #1;
      chk($sformatf("row%0d_ready", i),   {29'b0, bus.src_ready}, {29'b0, vt[i].rdy});
      chk($sformatf("row%0d_wr_en", i),   {31'b0, bus.wr_en},     {31'b0, vt[i].we});
      chk($sformatf("row%0d_wr_addr", i), {27'b0, bus.wr_addr},   {27'b0, vt[i].wa});
      chk($sformatf("row%0d_wr_data", i), bus.wr_data,            vt[i].wd);
      chk($sformatf("row%0d_wr_src", i),  {30'b0, bus.wr_src},    {30'b0, vt[i].ws});
      chk($sformatf("row%0d_busy", i),    {31'b0, bus.busy},      {31'b0, vt[i].busy});
    end

    // Starvation: src 0 streams, src 2 loads once and must be forced through at age 4.
    k0 = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      bus.src_valid = {s == 0, 1'b0, 1'b1};
      bus.src_addr  = {5'd5, 5'd0, s0_addr(k0)};
      bus.src_data  = {32'h55, 32'h0, s0_data(k0)};
      #1;
      case (s)
        0: chk("stv_s0_ready", {29'b0, bus.src_ready}, 32'b111);
        1: chk("stv_s1_wr_en", {31'b0, bus.wr_en}, 32'd0);
        2, 3, 4: begin
          chk($sformatf("stv_s%0d_wr_addr", s), {27'b0, bus.wr_addr}, 32'(20 + s - 2));
          chk($sformatf("stv_s%0d_wr_src", s), {30'b0, bus.wr_src}, 32'd0);
        end
        5: begin
          chk("stv_s5_wr_addr", {27'b0, bus.wr_addr}, 32'd23);
          chk("stv_s5_ready0", {31'b0, bus.src_ready[0]}, 32'd0);
`ifdef GPR_WB_FWD_EN
          bus.fwd_addr = 5'd12; #1;
          chk("fwd_buf_hit", {31'b0, bus.fwd_hit}, 32'd1);
          chk("fwd_buf_data", bus.fwd_data, 32'hABCD);
          bus.fwd_addr = 5'd13; #1;
          chk("fwd_miss_hit", {31'b0, bus.fwd_hit}, 32'd0);
          chk("fwd_miss_data", bus.fwd_data, 32'd0);
          bus.fwd_addr = 5'd23; #1;
          chk("fwd_wr_hit", {31'b0, bus.fwd_hit}, 32'd1);
          chk("fwd_wr_data", bus.fwd_data, 32'h203);
`endif
        end
        6: begin
          chk("stv_s6_wr_en", {31'b0, bus.wr_en}, 32'd1);
          chk("stv_s6_wr_src", {30'b0, bus.wr_src}, 32'd2);
          chk("stv_s6_wr_addr", {27'b0, bus.wr_addr}, 32'd5);
          chk("stv_s6_wr_data", bus.wr_data, 32'h55);
          chk("stv_s6_ready0", {31'b0, bus.src_ready[0]}, 32'd1);
        end
        default: begin
          chk("stv_s7_wr_src", {30'b0, bus.wr_src}, 32'd0);
          chk("stv_s7_wr_addr", {27'b0, bus.wr_addr}, 32'd12);
          chk("stv_s7_wr_data", bus.wr_data, 32'hABCD);
        end
      endcase
      if (bus.src_ready[0]) k0++;
    end
    bus.src_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("drain_wr_en", {31'b0, bus.wr_en}, 32'd0);
    chk("drain_busy", {31'b0, bus.busy}, 32'd0);

    // Reset mid-operation discards all three buffered results.
    @(negedge clk);
    bus.src_valid = 3'b111;
    bus.src_addr  = {5'd4, 5'd2, 5'd1};
    bus.src_data  = {32'hA3, 32'hA2, 32'hA1};
    #1;
    chk("rst_fill_ready", {29'b0, bus.src_ready}, 32'b111);
    @(negedge clk);
    bus.src_valid = '0;
    reset = 1'b1;
    #1;
    chk("rst_pre_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_ready", {29'b0, bus.src_ready}, 32'b111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_after%0d_wr_en", c), {31'b0, bus.wr_en}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Shares the single GPR-file write port between NUM_SRC result producers (ALU, load/store, multi-cycle unit).
- Each source has a one-entry holding buffer.
- A priority arbiter with anti-starvation aging picks one buffered result per cycle and drives a registered write port.
- Sits between the execute/LS stage outputs and the GPR file.
- wr_en/wr_addr also feed the data-hazard tracker as the write-completion event.

Parameters:
NUM_SRC, 3, number of result producers; index 0 is highest base priority
DATA_W, 32, GPR data width
ADDR_W, 5, GPR index width
STARVE_LIMIT, 4, cycles a buffered entry may lose arbitration before forced promotion (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  source i presents a result
src_ready  out  NUM_SRC  source i result accepted this cycle when valid&ready
src_addr  in  NUM_SRC*ADDR_W  destination GPR of source i (slice i at [i*ADDR_W +: ADDR_W])
src_data  in  NUM_SRC*DATA_W  result data of source i
wr_en  out  1  GPR-file write strobe (registered)
wr_addr  out  ADDR_W  GPR-file write index (registered)
wr_data  out  DATA_W  GPR-file write data (registered)
wr_src  out  $clog2(NUM_SRC)  index of source whose result is being written (registered)
busy  out  1  any holding buffer occupied

Behaviour:
- Reset (synchronous, active-high): all buffers empty, age counters 0, wr_en=0, wr_addr=0, wr_data=0, wr_src=0, busy=0. src_ready reads 1 for every source in the cycle after reset deasserts.
- Reset asserted mid-operation discards all buffered results with no write. Upstream squashes those instructions.
- Buffer i holds {addr, data} with flag full_i.
- src_ready[i] = !full_i | grant_i (skid behaviour: a buffer granted this cycle may reload the same cycle).
- Accept: at a clock edge with src_valid[i] & src_ready[i], buffer i loads src_addr/src_data and full_i=1.
  - If grant_i and no accept in that cycle, full_i clears.
- Arbitration is combinational over full_i each cycle:
  - If any full entry has age_i >= STARVE_LIMIT, grant the lowest-index such entry.
  - Else grant the lowest-index full entry.
  - At most one grant per cycle. No grant when all buffers are empty.
- Age: age_i resets to 0 on accept or when empty. It increments (saturating at 15) each cycle full_i & !grant_i.
- Write port: at the edge following a grant, wr_en=1 and wr_addr/wr_data/wr_src take the granted entry. With no grant, wr_en=0 and wr_addr/wr_data/wr_src hold their previous values.
- Latency: accept at edge N -> granted in cycle N -> wr_en high in cycle N+1 (uncontended).
- Throughput: one write per cycle sustained. A source streaming every cycle with no contention never sees src_ready low.
- Ordering precondition: two buffers never hold the same destination GPR. The hazard tracker guarantees this; a bench assertion checks it and the RTL does no address compare for ordering.
- busy = |full.

Optional Feature:
- Macro GPR_WB_FWD_EN.
- Defined:
  - Adds input fwd_addr (ADDR_W) and outputs fwd_hit (1) and fwd_data (DATA_W).
  - Combinational lookup over all full buffers plus the registered write port (wr_en).
  - Buffer match has priority over the write-port match.
  - fwd_hit=0 and fwd_data=0 on miss. Both are 0 after reset.
- Undefined: ports absent, no lookup logic.

Test Plan:
- Single source: reset, then src 1 valid one cycle with addr=7, data=0xDEADBEEF -> next cycle wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, wr_src=1. The following cycle wr_en=0 and busy=0.
- Collision: src 0 (addr 3, 0x11) and src 2 (addr 9, 0x22) accepted in the same cycle -> wr_en two consecutive cycles: first addr 3/0x11/src 0, then addr 9/0x22/src 2. src_ready[2] stays 0 until src 2 is granted.
- Starvation (STARVE_LIMIT=4): src 0 streams a new result every cycle; src 2 loads once with addr 5 -> src 2 written exactly when its age reaches 4, i.e. wr_src=2 on the 5th write cycle after its accept. The src 0 result granted next is delayed one cycle, with src_ready[0]=0 for that cycle.
- Skid: src 1 valid every cycle for 8 cycles with no other traffic -> src_ready[1] constantly 1 and 8 back-to-back writes in order.
- Reset mid-operation: fill all three buffers, assert reset one cycle -> wr_en=0 and busy=0 after reset, with no write of any buffered data.
- GPR_WB_FWD_EN: src 0 buffered with addr 12 = 0xABCD while stalled behind a starving src 2, fwd_addr=12 -> fwd_hit=1, fwd_data=0xABCD. With fwd_addr=13 -> fwd_hit=0.
